// File: rtl/bcd_print_sequencer.sv
// Sequences the shared binary-to-BCD converter and streams the value as ASCII decimal
// with leading zeros suppressed. Define BCD_PRINT_CRLF_EN to append CR LF after each number.
module bcd_print_sequencer #(
    parameter int CONV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_value,
    output logic        req_ready,
    output logic        conv_start,
    output logic [31:0] conv_binary,
    input  logic [39:0] conv_bcd,
    input  logic        conv_done,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
`ifdef BCD_PRINT_CRLF_EN
        S_TAIL,
`endif
        S_EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] conv_binary_q;
    logic [39:0] digits_q;
    logic [3:0]  idx_q;
    logic        one_char_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic [3:0]  first_nz;
    logic [3:0]  cur_nib;
    logic        timeout;
    logic        last_char;
    logic        accept;
`ifdef BCD_PRINT_CRLF_EN
    logic        tail_q;
`endif

    assign accept      = req_valid && (state_q == S_IDLE);
    assign timeout     = (cnt_q == 8'(CONV_TIMEOUT - 1)) && !conv_done;
    assign last_char   = one_char_q || (idx_q == 4'd9);
    assign conv_binary = conv_binary_q;
    assign err         = err_q;

    // Digit 0 is the most significant; all-zero results point at the units digit.
    always_comb begin
        first_nz = 4'd9;
        for (int i = 8; i >= 0; i--) begin
            if (conv_bcd[4*(9-i) +: 4] != 4'h0)
                first_nz = 4'(i);
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < 10; i++) begin
            if (idx_q == 4'(i))
                cur_nib = digits_q[39-4*i -: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        conv_start = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = 1'b1;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    state_d = S_START;
            end
            S_START: begin
                conv_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done || timeout)
                    state_d = S_EMIT;
            end
            S_EMIT: begin
                tx_valid = 1'b1;
                tx_data  = one_char_q ? 8'h3F : (8'h30 + {4'h0, cur_nib});
                if (tx_ready && last_char)
`ifdef BCD_PRINT_CRLF_EN
                    state_d = S_TAIL;
`else
                    state_d = S_IDLE;
`endif
            end
`ifdef BCD_PRINT_CRLF_EN
            S_TAIL: begin
                tx_valid = 1'b1;
                tx_data  = tail_q ? 8'h0A : 8'h0D;
                if (tx_ready && tail_q)
                    state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_binary_q <= 32'h0;
            digits_q      <= 40'h0;
            idx_q         <= 4'd0;
            one_char_q    <= 1'b0;
            cnt_q         <= 8'd0;
            err_q         <= 1'b0;
`ifdef BCD_PRINT_CRLF_EN
            tail_q        <= 1'b0;
`endif
        end else begin
            if (accept) begin
                conv_binary_q <= req_value;
                err_q         <= 1'b0;
            end
            case (state_q)
                S_START: begin
                    cnt_q <= 8'd0;
`ifdef BCD_PRINT_CRLF_EN
                    tail_q <= 1'b0;
`endif
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (conv_done) begin
                        digits_q   <= conv_bcd;
                        idx_q      <= first_nz;
                        one_char_q <= 1'b0;
                    end else if (timeout) begin
                        err_q      <= 1'b1;
                        one_char_q <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (tx_ready && !last_char)
                        idx_q <= idx_q + 4'd1;
                end
`ifdef BCD_PRINT_CRLF_EN
                S_TAIL: begin
                    if (tx_ready)
                        tail_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bcd_print_sequencer.md
# bcd_print_sequencer

Controller that sequences the shared 32-bit binary-to-BCD converter in the UART AHB-Lite subsystem to print unsigned decimal numbers. It accepts a 32-bit value, starts the converter, waits for its result, and streams the ASCII decimal digits with leading zeros suppressed over a valid/ready byte interface toward the UART transmit path. A watchdog guards against a converter that never completes.

## Interface
- CONV_TIMEOUT, 64: max WAIT cycles before abort; legal range 40..255
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  print request present
- req_value  in  32  unsigned value to print
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
- conv_start  out  1  one-cycle start pulse to converter
- conv_binary  out  32  operand to converter, registered at accept, stable until next accept
- conv_bcd  in  40  converter result; [39:36] = most significant digit
- conv_done  in  1  converter done (level; stale until cleared by next start)
- tx_valid  out  1  character valid
- tx_data  out  8  ASCII character
- tx_ready  in  1  sink accepts character
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag; cleared on next accept

## Operation
- States: IDLE, START, WAIT, EMIT, TAIL (TAIL only with CRLF feature).
- IDLE: req_ready=1. On accept, latch req_value into conv_binary, clear err, go START.
- START: conv_start=1 for exactly this cycle, clear timeout counter, go WAIT.
- WAIT: conv_done sampled only here (stale done from the previous conversion is cleared by the start edge, so it is already low in the first WAIT cycle). Counter increments each WAIT cycle.
  - conv_done=1: capture conv_bcd into the digit register. Compute index of first nonzero digit (priority encoder, MSD first); all-zero gives index 9 (the units digit). Go EMIT.
  - Counter reaches CONV_TIMEOUT with done low: set err, load single character '?' (0x3F), go EMIT in one-char mode.
- EMIT: tx_data = 0x30 + digit[index]. tx_valid held, tx_data stable, until tx_ready. On handshake, index+1. After index 9 (or the '?'), go TAIL if enabled, else IDLE.
- Digit nibbles greater than 9 are not checked; emitted as 0x30+nibble.
- No new request is accepted until return to IDLE.
- Reset mid-operation: all state is dropped immediately. conv_start is not reissued. A converter still running is ignored. Its later done is never sampled outside WAIT.

## Timing
- Reset values: req_ready=1, conv_start=0, conv_binary=0, tx_valid=0, tx_data=0x00, busy=0, err=0.
- Accept in cycle 0 -> conv_start in cycle 1 -> WAIT from cycle 2.
- conv_done first seen high in cycle N -> tx_valid=1 in cycle N+1.
- With the companion converter, done is first seen in cycle 33. First character is therefore valid in cycle 34.
- With tx_ready held at 1, one character transfers per cycle.
- Return to IDLE: req_ready=1 the cycle after the final handshake.
- busy is asserted from cycle 1 through the final handshake.
- Timeout: err=1 and '?' valid in cycle 2+CONV_TIMEOUT.

## Configuration
- BCD_PRINT_CRLF_EN defined:
  - After the last digit (or '?'), TAIL emits 0x0D then 0x0A with the same valid/ready rules, then returns to IDLE.
- Not defined:
  - TAIL state and logic are absent. The sequencer returns to IDLE after the last digit.

## Test plan
- Value 0, tx_ready=1 -> single char 0x30. With CRLF: 0x30,0x0D,0x0A. Then req_ready=1.
- Value 4294967295 -> "4294967295" (10 chars), first tx_valid in cycle 34 after accept, conv_start pulsed exactly once.
- Value 1000, tx_ready toggling 1-0-0-1 -> "1000". tx_data stable while tx_valid & !tx_ready. No char duplicated or dropped.
- conv_done tied 0, CONV_TIMEOUT=40 -> err=1 and '?' valid in cycle 42. Next accept clears err.
- Stale conv_done held 1 from the previous conversion, new request 57 -> no early emit. Output "57" only after the fresh done.
- rst asserted mid-EMIT of 12345 -> all outputs at reset values immediately. A subsequent request of 7 prints "7" only.
